// File: rtl/hazard_pkg.sv
// Shared definitions for the ID-stage hazard detection unit.
// State encoding and next-PC select codes used by the unit and its bench.
package hazard_pkg;

    typedef enum logic {
        S_NORMAL  = 1'b0,
        S_BR_WAIT = 1'b1
    } state_t;

    localparam logic [1:0] ADDR_PC4 = 2'b00;
    localparam logic [1:0] ADDR_JMP = 2'b01;
    localparam logic [1:0] ADDR_BR  = 2'b10;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with enable and asynchronous active-low reset.
// Holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    output logic [STAT_W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (en && (count != {STAT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_detection_unit.sv
// Load-use stall detection and branch/jump sequencing for the ID stage.
// Optional statistics counters are built when HAZARD_STATS_EN is defined.
module hazard_detection_unit
    import hazard_pkg::*;
#(
    parameter int REG_W  = 5,
    parameter int STAT_W = 16
) (
    input  logic             CLK,
    input  logic             Reset_L,
    input  logic             IDEX_MemRead,
    input  logic [REG_W-1:0] IDEX_Rt,
    input  logic [REG_W-1:0] IFID_Rs,
    input  logic [REG_W-1:0] IFID_Rt,
    input  logic             UseShamt,
    input  logic             Jump,
    input  logic             Branch,
    input  logic             ALUZero,
    output logic             bubble,
    output logic             PCWrite,
    output logic             IFWrite,
    output logic             IFFlush,
    output logic [1:0]       addrSel,
    output state_t           dbg_state
`ifdef HAZARD_STATS_EN
    ,
    output logic [STAT_W-1:0] stall_cnt,
    output logic [STAT_W-1:0] flush_cnt
`endif
);

    if (STAT_W < 1) begin : g_bad_stat_w
        $error("STAT_W must be at least 1");
    end

    state_t state;
    state_t next_state;
    logic   rs_hit;
    logic   rt_hit;
    logic   load_use;

    // Shift-by-shamt instructions do not read rs, so rs cannot create a hazard.
    assign rs_hit   = (IDEX_Rt == IFID_Rs) && !UseShamt;
    assign rt_hit   = (IDEX_Rt == IFID_Rt);
    assign load_use = IDEX_MemRead && (IDEX_Rt != '0) && (rs_hit || rt_hit);

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            state <= S_NORMAL;
        end else begin
            state <= next_state;
        end
    end

    // Outputs are Mealy; reset is folded in so the pipeline is frozen while Reset_L is low.
    always_comb begin
        next_state = state;
        bubble     = 1'b0;
        PCWrite    = 1'b0;
        IFWrite    = 1'b0;
        IFFlush    = 1'b0;
        addrSel    = ADDR_PC4;
        if (!Reset_L) begin
            bubble     = 1'b1;
            next_state = S_NORMAL;
        end else begin
            case (state)
                S_NORMAL: begin
                    if (load_use) begin
                        bubble = 1'b1;
                    end else if (Jump) begin
                        PCWrite = 1'b1;
                        IFWrite = 1'b1;
                        IFFlush = 1'b1;
                        addrSel = ADDR_JMP;
                    end else if (Branch) begin
                        // Branch goes to EX; the fall-through word stays held in IF/ID.
                        next_state = S_BR_WAIT;
                    end else begin
                        PCWrite = 1'b1;
                        IFWrite = 1'b1;
                    end
                end
                S_BR_WAIT: begin
                    bubble     = 1'b1;
                    next_state = S_NORMAL;
                    if (ALUZero) begin
                        PCWrite = 1'b1;
                        IFWrite = 1'b1;
                        IFFlush = 1'b1;
                        addrSel = ADDR_BR;
                    end
                end
                default: begin
                    next_state = S_NORMAL;
                end
            endcase
        end
    end

    assign dbg_state = state;

`ifdef HAZARD_STATS_EN
    logic stall_ev;
    logic flush_ev;

    assign stall_ev = (state == S_NORMAL) && load_use;
    assign flush_ev = IFFlush;

    sat_counter #(.STAT_W(STAT_W)) u_stall_cnt (
        .clk   (CLK),
        .rst_n (Reset_L),
        .en    (stall_ev),
        .count (stall_cnt)
    );

    sat_counter #(.STAT_W(STAT_W)) u_flush_cnt (
        .clk   (CLK),
        .rst_n (Reset_L),
        .en    (flush_ev),
        .count (flush_cnt)
    );
`endif

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Self-checking bench for hazard_detection_unit: directed cases plus random traffic
// compared each cycle against an action-level reference model (stats when HAZARD_STATS_EN).
module tb_hazard_detection_unit;
    import hazard_pkg::*;

    localparam int REG_W     = 5;
    localparam int TB_STAT_W = 4;

    logic             CLK = 1'b0;
    logic             Reset_L = 1'b0;
    logic             IDEX_MemRead = 1'b0;
    logic [REG_W-1:0] IDEX_Rt = '0;
    logic [REG_W-1:0] IFID_Rs = '0;
    logic [REG_W-1:0] IFID_Rt = '0;
    logic             UseShamt = 1'b0;
    logic             Jump = 1'b0;
    logic             Branch = 1'b0;
    logic             ALUZero = 1'b0;
    logic             bubble;
    logic             PCWrite;
    logic             IFWrite;
    logic             IFFlush;
    logic [1:0]       addrSel;
    state_t           dbg_state;
`ifdef HAZARD_STATS_EN
    logic [TB_STAT_W-1:0] stall_cnt;
    logic [TB_STAT_W-1:0] flush_cnt;
`endif

    int n_vec  = 0;
    int n_fail = 0;

    hazard_detection_unit #(.REG_W(REG_W), .STAT_W(TB_STAT_W)) dut (
        .CLK          (CLK),
        .Reset_L      (Reset_L),
        .IDEX_MemRead (IDEX_MemRead),
        .IDEX_Rt      (IDEX_Rt),
        .IFID_Rs      (IFID_Rs),
        .IFID_Rt      (IFID_Rt),
        .UseShamt     (UseShamt),
        .Jump         (Jump),
        .Branch       (Branch),
        .ALUZero      (ALUZero),
        .bubble       (bubble),
        .PCWrite      (PCWrite),
        .IFWrite      (IFWrite),
        .IFFlush      (IFFlush),
        .addrSel      (addrSel),
        .dbg_state    (dbg_state)
`ifdef HAZARD_STATS_EN
        ,
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
`endif
    );

    // ---------------- clock ----------------
    always #5 CLK = ~CLK;

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Control word packed as {bubble, PCWrite, IFWrite, IFFlush, addrSel}.
    localparam logic [5:0] A_FROZEN  = 6'b1_0_0_0_00; // reset, stall, branch not taken
    localparam logic [5:0] A_JUMP    = 6'b0_1_1_1_01;
    localparam logic [5:0] A_BR_HOLD = 6'b0_0_0_0_00;
    localparam logic [5:0] A_TAKEN   = 6'b1_1_1_1_10;
    localparam logic [5:0] A_RUN     = 6'b0_1_1_0_00;

    function automatic bit model_load_use(input bit mr, input int ert, input int rs,
                                          input int rt, input bit sh);
        if (!mr || ert == 0) return 1'b0;
        return ((ert == rs) && !sh) || (ert == rt);
    endfunction

    // ---------------- reference model ----------------
    bit m_wait     = 1'b0;
    bit m_wait_nxt = 1'b0;
    bit m_stall_ev = 1'b0;
    bit m_flush_ev = 1'b0;
    int m_stall    = 0;
    int m_flush    = 0;
    bit check_en   = 1'b1;

    always @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            m_wait  <= 1'b0;
            m_stall <= 0;
            m_flush <= 0;
        end else begin
            m_wait <= m_wait_nxt;
            if (m_stall_ev && m_stall < (1 << TB_STAT_W) - 1) m_stall <= m_stall + 1;
            if (m_flush_ev && m_flush < (1 << TB_STAT_W) - 1) m_flush <= m_flush + 1;
        end
    end

    // Compare process: inputs are stable between posedge+1 and the next posedge.
    always @(negedge CLK) begin
        logic [5:0] exp_ctl;
        bit lu;
        lu = model_load_use(IDEX_MemRead, int'(IDEX_Rt), int'(IFID_Rs), int'(IFID_Rt), UseShamt);
        if (!Reset_L)      exp_ctl = A_FROZEN;
        else if (m_wait)   exp_ctl = ALUZero ? A_TAKEN : A_FROZEN;
        else if (lu)       exp_ctl = A_FROZEN;
        else if (Jump)     exp_ctl = A_JUMP;
        else if (Branch)   exp_ctl = A_BR_HOLD;
        else               exp_ctl = A_RUN;
        m_wait_nxt <= Reset_L && !m_wait && !lu && !Jump && Branch;
        m_stall_ev <= Reset_L && !m_wait && lu;
        m_flush_ev <= exp_ctl[2];
        if (check_en) begin
            check("ctl", {26'd0, bubble, PCWrite, IFWrite, IFFlush, addrSel}, {26'd0, exp_ctl});
            check("state", {31'd0, dbg_state}, {31'd0, m_wait});
`ifdef HAZARD_STATS_EN
            check("stall_cnt", {28'd0, stall_cnt}, 32'(m_stall));
            check("flush_cnt", {28'd0, flush_cnt}, 32'(m_flush));
`endif
        end
    end

    // ---------------- driver ----------------
    task automatic drive(input bit rst_n, input bit mr, input int ert, input int rs,
                         input int rt, input bit sh, input bit j, input bit b, input bit z);
        @(posedge CLK);
        #1;
        Reset_L      = rst_n;
        IDEX_MemRead = mr;
        IDEX_Rt      = REG_W'(ert);
        IFID_Rs      = REG_W'(rs);
        IFID_Rt      = REG_W'(rt);
        UseShamt     = sh;
        Jump         = j;
        Branch       = b;
        ALUZero      = z;
        #1;
    endtask

    task automatic idle();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        Jump = 1'b1;
        // 1: reset held with Jump asserted, then first active cycle jumps
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
            check("rst_pcwrite", {31'd0, PCWrite}, 32'd0);
            check("rst_ifwrite", {31'd0, IFWrite}, 32'd0);
            check("rst_bubble", {31'd0, bubble}, 32'd1);
        end
        drive(1, 0, 0, 0, 0, 0, 1, 0, 0);
        check("rel_pcwrite", {31'd0, PCWrite}, 32'd1);
        check("rel_addrsel", {30'd0, addrSel}, 32'h1);
        check("rel_ifflush", {31'd0, IFFlush}, 32'd1);
        idle();

        // 2: load-use on rs, then the no-stall variants
        drive(1, 1, 5, 5, 0, 0, 0, 0, 0);
        check("lu_bubble", {31'd0, bubble}, 32'd1);
        check("lu_pcwrite", {31'd0, PCWrite}, 32'd0);
        check("lu_ifwrite", {31'd0, IFWrite}, 32'd0);
        idle();
        check("lu_once", {31'd0, PCWrite}, 32'd1);
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
        check("lu_r0", {31'd0, bubble}, 32'd0);
        drive(1, 1, 5, 5, 0, 1, 0, 0, 0);
        check("lu_shamt", {31'd0, PCWrite}, 32'd1);

        // 3: taken then not-taken branch
        drive(1, 0, 0, 0, 0, 0, 0, 1, 0);
        check("br1_pcwrite", {31'd0, PCWrite}, 32'd0);
        check("br1_bubble", {31'd0, bubble}, 32'd0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1);
        check("tk_bubble", {31'd0, bubble}, 32'd1);
        check("tk_addrsel", {30'd0, addrSel}, 32'h2);
        check("tk_ifflush", {31'd0, IFFlush}, 32'd1);
        check("tk_pcwrite", {31'd0, PCWrite}, 32'd1);
        drive(1, 0, 0, 0, 0, 0, 0, 1, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        check("nt_pcwrite", {31'd0, PCWrite}, 32'd0);
        check("nt_ifflush", {31'd0, IFFlush}, 32'd0);
        check("nt_bubble", {31'd0, bubble}, 32'd1);

        // 4: load-use beats branch, then branch proceeds
        drive(1, 1, 8, 0, 8, 0, 0, 1, 0);
        check("lub_bubble", {31'd0, bubble}, 32'd1);
        check("lub_state", {31'd0, dbg_state}, 32'(S_NORMAL));
        drive(1, 0, 8, 0, 8, 0, 0, 1, 0);
        check("lub_state2", {31'd0, dbg_state}, 32'(S_NORMAL));
        check("lub_br_bubble", {31'd0, bubble}, 32'd0);
        idle();
        check("lub_wait", {31'd0, dbg_state}, 32'(S_BR_WAIT));

        // 5: reset while waiting on a branch aborts it
        drive(1, 0, 0, 0, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        check("abort_state", {31'd0, dbg_state}, 32'(S_NORMAL));
        check("abort_flush", {31'd0, IFFlush}, 32'd0);
        check("abort_bubble", {31'd0, bubble}, 32'd1);
        idle();
        check("abort_run", {31'd0, PCWrite}, 32'd1);

`ifdef HAZARD_STATS_EN
        // 6: counter saturation and flush counting from a fresh reset
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) drive(1, 1, 5, 5, 0, 0, 0, 0, 0);
        idle();
        check("stall_sat", {28'd0, stall_cnt}, 32'hF);
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 0, 0, 0, 0, 1, 0);
            drive(1, 0, 0, 0, 0, 0, 0, 0, 1);
        end
        idle();
        check("flush_three", {28'd0, flush_cnt}, 32'd3);
`endif

        // random traffic; small register range so hazards are frequent
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 63) != 0),
                  $urandom_range(0, 1),
                  int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 3) == 0),
                  $urandom_range(0, 1));
        end
        idle();
        @(posedge CLK);
        #1;
        check_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
